// File: rtl/board_move_ctrl.sv
// Chess board register and move controller: cursor navigation, select/confirm, one-cycle commit.
// Optional pawn-to-queen promotion at commit when BOARD_PROMO_EN is defined.
module board_move_ctrl #(
  parameter logic [3:0] EMPTY_CODE = 4'd15,
  parameter logic [3:0] KING_W     = 4'd4,
  parameter logic [3:0] KING_B     = 4'd10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_active,
  input  logic       new_game,
  input  logic       key_col,
  input  logic       key_row,
  input  logic       key_enter,
  output logic [3:0] board [8][8],
  output logic [2:0] cursor_row,
  output logic [2:0] cursor_col,
  output logic       sel_valid,
  output logic [2:0] sel_row,
  output logic [2:0] sel_col,
  output logic       turn,
  output logic       move_done,
  output logic       king_taken,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {PICK = 2'd0, PLACE = 2'd1, COMMIT = 2'd2} state_t;

  state_t     state, state_next;
  logic [2:0] dst_row, dst_col;
  logic       do_select, do_cancel, do_dst, do_commit, cursor_en;
  logic [3:0] cur_code, moved_code, dst_old;
  logic       cur_owned;

  function automatic logic [3:0] init_code(input int r, input int c);
    logic [3:0] back;
    case (c)
      0, 7:    back = 4'd0;
      1, 6:    back = 4'd1;
      2, 5:    back = 4'd2;
      3:       back = 4'd3;
      default: back = 4'd4;
    endcase
    case (r)
      0:       return back;
      1:       return 4'd5;
      6:       return 4'd11;
      7:       return back + 4'd6;
      default: return EMPTY_CODE;
    endcase
  endfunction

  function automatic logic owned(input logic [3:0] code, input logic side);
    return side ? (code >= 4'd6 && code <= 4'd11) : (code <= 4'd5);
  endfunction

  assign state_dbg = state;
  assign cur_code  = board[cursor_row][cursor_col];
  assign cur_owned = owned(cur_code, turn);
  assign dst_old   = board[dst_row][dst_col];

  always_comb begin
    moved_code = board[sel_row][sel_col];
`ifdef BOARD_PROMO_EN
    if (moved_code == 4'd5 && dst_row == 3'd7) moved_code = 4'd3;
    else if (moved_code == 4'd11 && dst_row == 3'd0) moved_code = 4'd9;
`endif
  end

  // key_enter decisions use the cursor as it stood before this edge's movement
  always_comb begin
    state_next = state;
    do_select  = 1'b0;
    do_cancel  = 1'b0;
    do_dst     = 1'b0;
    do_commit  = 1'b0;
    cursor_en  = 1'b0;
    if (!game_active) begin
      state_next = PICK;
    end else begin
      cursor_en = (state != COMMIT);
      case (state)
        PICK: begin
          if (key_enter && !king_taken && cur_owned) begin
            do_select  = 1'b1;
            state_next = PLACE;
          end
        end
        PLACE: begin
          if (key_enter) begin
            if (cursor_row == sel_row && cursor_col == sel_col) begin
              do_cancel  = 1'b1;
              state_next = PICK;
            end else if (cur_owned) begin
              do_select = 1'b1;
            end else begin
              do_dst     = 1'b1;
              state_next = COMMIT;
            end
          end
        end
        COMMIT: begin
          do_commit  = 1'b1;
          state_next = PICK;
        end
        default: state_next = PICK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      state <= PICK;
    else if (new_game) state <= PICK;
    else               state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r[2:0]][c[2:0]] <= init_code(r, c);
      cursor_row <= '0;
      cursor_col <= '0;
      sel_valid  <= 1'b0;
      sel_row    <= '0;
      sel_col    <= '0;
      dst_row    <= '0;
      dst_col    <= '0;
      turn       <= 1'b0;
      move_done  <= 1'b0;
      king_taken <= 1'b0;
    end else if (new_game) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r[2:0]][c[2:0]] <= init_code(r, c);
      cursor_row <= '0;
      cursor_col <= '0;
      sel_valid  <= 1'b0;
      sel_row    <= '0;
      sel_col    <= '0;
      dst_row    <= '0;
      dst_col    <= '0;
      turn       <= 1'b0;
      move_done  <= 1'b0;
      king_taken <= 1'b0;
    end else begin
      move_done <= 1'b0;
      if (!game_active) sel_valid <= 1'b0;
      if (cursor_en && key_col) cursor_col <= cursor_col + 3'd1;
      if (cursor_en && key_row) cursor_row <= cursor_row + 3'd1;
      if (do_select) begin
        sel_row   <= cursor_row;
        sel_col   <= cursor_col;
        sel_valid <= 1'b1;
      end
      if (do_cancel) sel_valid <= 1'b0;
      if (do_dst) begin
        dst_row <= cursor_row;
        dst_col <= cursor_col;
      end
      if (do_commit) begin
        board[dst_row][dst_col] <= moved_code;
        board[sel_row][sel_col] <= EMPTY_CODE;
        turn      <= ~turn;
        sel_valid <= 1'b0;
        move_done <= 1'b1;
        if (dst_old == KING_W || dst_old == KING_B) king_taken <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed bench for board_move_ctrl: expected move results queue up at confirm time and a
// negedge monitor pops one per move_done pulse; set-up checks run inline.
module tb_board_move_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_active = 1'b0;
  logic       new_game = 1'b0;
  logic       key_col = 1'b0;
  logic       key_row = 1'b0;
  logic       key_enter = 1'b0;
  logic [3:0] board [8][8];
  logic [2:0] cursor_row, cursor_col, sel_row, sel_col;
  logic       sel_valid, turn, move_done, king_taken;
  logic [1:0] state_dbg;

  board_move_ctrl dut (
    .clk(clk), .reset_n(reset_n), .game_active(game_active), .new_game(new_game),
    .key_col(key_col), .key_row(key_row), .key_enter(key_enter), .board(board),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .sel_valid(sel_valid),
    .sel_row(sel_row), .sel_col(sel_col), .turn(turn), .move_done(move_done),
    .king_taken(king_taken), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  int          mb [8][8];
  int          cr, cc, mturn, mking;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_init(input int r, input int c);
    int back [8] = '{0, 1, 2, 3, 4, 2, 1, 0};
    int top  [8] = '{6, 7, 8, 9, 10, 8, 7, 6};
    if (r == 0) return back[c];
    if (r == 1) return 5;
    if (r == 6) return 11;
    if (r == 7) return top[c];
    return 15;
  endfunction

  task automatic reset_model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = exp_init(r, c);
    cr = 0; cc = 0; mturn = 0; mking = 0;
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s_sq_%0d_%0d", tag, r, c), board[r[2:0]][c[2:0]], mb[r][c]);
  endtask

  // Drive one cycle of key pulses; mv says whether the cursor model should follow.
  task automatic pulse(input logic kc, input logic kr, input logic ke, input logic mv);
    key_col = kc; key_row = kr; key_enter = ke;
    @(negedge clk);
    key_col = 1'b0; key_row = 1'b0; key_enter = 1'b0;
    if (mv && kc) cc = (cc + 1) % 8;
    if (mv && kr) cr = (cr + 1) % 8;
  endtask

  task automatic goto(input int r, input int c);
    while (cr != r || cc != c) pulse(cc != c, cr != r, 1'b0, 1'b1);
    chk("goto_row", cursor_row, r);
    chk("goto_col", cursor_col, c);
  endtask

  task automatic do_move(input int sr, input int sc, input int dr, input int dc, input logic drop_key);
    int code;
    logic [17:0] e;
    goto(sr, sc);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    goto(dr, dc);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    code = mb[sr][sc];
`ifdef BOARD_PROMO_EN
    if (code == 5 && dr == 7) code = 3;
    else if (code == 11 && dr == 0) code = 9;
`endif
    if (mb[dr][dc] == 4 || mb[dr][dc] == 10) mking = 1;
    mb[dr][dc] = code;
    mb[sr][sc] = 15;
    mturn = mturn ^ 1;
    e = {dr[2:0], dc[2:0], code[3:0], sr[2:0], sc[2:0], mturn[0], mking[0]};
    exp_q.push_back(e);
    if (drop_key) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    else @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset_n && move_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_move_done: got 1, expected 0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_dst_code", board[mon_e[17:15]][mon_e[14:12]], mon_e[11:8]);
        chk("sb_src_empty", board[mon_e[7:5]][mon_e[4:2]], 15);
        chk("sb_turn", turn, mon_e[1]);
        chk("sb_king", king_taken, mon_e[0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    game_active = 1'b1;
    @(negedge clk);

    check_board("reset");
    chk("reset_cursor_row", cursor_row, 0);
    chk("reset_cursor_col", cursor_col, 0);
    chk("reset_turn", turn, 0);
    chk("reset_sel_valid", sel_valid, 0);
    chk("reset_king", king_taken, 0);
    chk("reset_move_done", move_done, 0);
    chk("reset_state", state_dbg, 0);

    // column wrap after 8 presses, then both keys together
    repeat (8) pulse(1'b1, 1'b0, 1'b0, 1'b1);
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 0);
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    chk("both_row", cursor_row, 1);
    chk("both_col", cursor_col, 1);

    // select then move white pawn (1,4)->(3,4)
    goto(1, 4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sel_valid_set", sel_valid, 1);
    chk("sel_row", sel_row, 1);
    chk("sel_col", sel_col, 4);
    chk("sel_state_place", state_dbg, 1);
    goto(3, 4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("confirm_no_early_done", move_done, 0);
    chk("confirm_board_held", board[3][4], 15);
    mb[3][4] = 5; mb[1][4] = 15; mturn = 1;
    exp_q.push_back({3'd3, 3'd4, 4'd5, 3'd1, 3'd4, 1'b1, 1'b0});
    @(negedge clk);
    chk("latency_move_done", move_done, 1);
    chk("move1_dst", board[3][4], 5);
    chk("move1_src", board[1][4], 15);
    chk("move1_turn", turn, 1);
    @(negedge clk);
    chk("move_done_one_cycle", move_done, 0);

    do_move(6, 7, 4, 7, 1'b0);

    // ownership, reselect and cancel
    goto(6, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("opp_no_select", sel_valid, 0);
    goto(0, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sel_knight", sel_valid, 1);
    goto(1, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("reselect_row", sel_row, 1);
    chk("reselect_col", sel_col, 1);
    chk("reselect_valid", sel_valid, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cancel_valid", sel_valid, 0);
    chk("cancel_state", state_dbg, 0);

    // white rook captures black king
    do_move(0, 0, 7, 4, 1'b0);
    chk("king_taken", king_taken, 1);
    goto(6, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("king_blocks_select", sel_valid, 0);

    // new_game restores everything
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    reset_model();
    check_board("newgame");
    chk("ng_king", king_taken, 0);
    chk("ng_turn", turn, 0);
    chk("ng_cursor_row", cursor_row, 0);
    chk("ng_cursor_col", cursor_col, 0);

    // abort an in-flight commit by dropping game_active
    goto(1, 2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    goto(3, 2);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    chk("abort_in_commit", state_dbg, 2);
    game_active = 1'b0;
    @(negedge clk);
    chk("abort_no_done", move_done, 0);
    chk("abort_src", board[1][2], 5);
    chk("abort_dst", board[3][2], 15);
    chk("abort_turn", turn, 0);
    chk("abort_sel", sel_valid, 0);
    chk("abort_state", state_dbg, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("inactive_cursor_col", cursor_col, 2);
    game_active = 1'b1;

    // enter uses the pre-move cursor when paired with a cursor key
    goto(1, 2);
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    chk("same_cycle_sel_row", sel_row, 1);
    chk("same_cycle_sel_col", sel_col, 2);
    chk("same_cycle_cursor_col", cursor_col, 3);
    goto(1, 2);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("same_cycle_cancel", sel_valid, 0);

    // pawns to the far rank; cursor keys during COMMIT are dropped
    do_move(1, 0, 7, 1, 1'b0);
`ifdef BOARD_PROMO_EN
    chk("promo_white", board[7][1], 3);
`else
    chk("nopromo_white", board[7][1], 5);
`endif
    do_move(6, 7, 0, 6, 1'b1);
    chk("commit_drop_row", cursor_row, 0);
    chk("commit_drop_col", cursor_col, 6);
`ifdef BOARD_PROMO_EN
    chk("promo_black", board[0][6], 9);
`else
    chk("nopromo_black", board[0][6], 11);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
